// File: rtl/mips_defs.sv
// Shared MIPS decode constants and multiply/divide operation codes.
// Used by the decoder to drive start/op/md_use and by the HI/LO sequencer.
package mips_defs;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // Ops that occupy the unit for a busy period (value 7 is treated as NONE).
    function automatic logic md_is_arith(logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_mult(logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// E-stage <-> multiply/divide unit signal bundle.
// master = pipeline side, slave = muldiv_ctrl.
interface muldiv_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_D;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, md_use_D,
                    input  busy, stall_req, hi, lo);
    modport slave  (input  start, op, a, b, md_use_D,
                    output busy, stall_req, hi, lo);
endinterface

// File: rtl/md_calc.sv
// Combinational HI/LO result for the latched op; divide by zero returns the
// current HI/LO so the register write becomes a no-op.
module md_calc
    import mips_defs::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [63:0] res_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot_s, rem_s;

    assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign prod_u = {32'b0, a_i} * {32'b0, b_i};

    // Signed divide on magnitudes: avoids the INT_MIN / -1 overflow case and
    // still yields 0x80000000 / 0 for it after sign restore.
    assign a_mag  = a_i[31] ? (32'd0 - a_i) : a_i;
    assign b_mag  = b_i[31] ? (32'd0 - b_i) : b_i;
    assign q_mag  = a_mag / b_mag;
    assign r_mag  = a_mag % b_mag;
    assign quot_s = (a_i[31] ^ b_i[31]) ? (32'd0 - q_mag) : q_mag;
    assign rem_s  = a_i[31] ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        res_o = {hi_i, lo_i};
        case (op_i)
            MD_MULT:  res_o = prod_s;
            MD_MULTU: res_o = prod_u;
            MD_DIV:   if (b_i != 32'd0) res_o = {rem_s, quot_s};
            MD_DIVU:  if (b_i != 32'd0) res_o = {a_i % b_i, a_i / b_i};
            default:  res_o = {hi_i, lo_i};
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle mult/div sequencer owning HI/LO; busy for N cycles per op,
// results land the cycle busy falls; stall_req holds a D-stage HI/LO user.
module muldiv_ctrl
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_ctrl_if.slave md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [63:0]   calc_res;
    logic          last_cyc;
    logic          accept;

    md_calc u_calc (
        .op_i  (op_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .res_o (calc_res)
    );

    // A new op is taken in IDLE or on the final busy edge, giving zero-gap issue.
    assign last_cyc = (state_q == RUN) && (cnt_q == CW'(1));
    assign accept   = md.start && md_is_arith(md.op) && ((state_q == IDLE) || last_cyc);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (md.start && (md.op == MD_MTHI)) hi_d = md.a;
                if (md.start && (md.op == MD_MTLO)) lo_d = md.a;
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (last_cyc) begin
                    {hi_d, lo_d} = calc_res;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            op_d    = md.op;
            a_d     = md.a;
            b_d     = md.b;
            cnt_d   = md_is_mult(md.op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md.busy      = (state_q == RUN);
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;
    assign md.stall_req = md.md_use_D && ((state_q == RUN) || (md.start && md_is_arith(md.op)));

endmodule
